reservation_station: RTL and testbench

- Buffers decoded integer/branch/jump instructions from the dispatcher until both source operands are available.
- Snoops the two common data buses (ALU and load/store) for ROB-tagged results and wakes up waiting operands.
- Issues at most one ready entry per cycle to the arithmetic logic unit through registered outputs.
- Sits between the dispatcher and the ALU, and is flushed by the reorder buffer on misprediction.

---
 rtl/reservation_station_pkg.sv | 77 +++++++
 rtl/reservation_station_if.sv | 59 +++++
 rtl/reservation_station_priority_picker.sv | 26 ++
 rtl/reservation_station.sv | 162 ++++++++++++++++
 tb/tb_reservation_station.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/reservation_station_pkg.sv
// Shared types for the reservation station: word/tag widths, inner opcodes,
// entry and issue records, and the common-data-bus snoop helper.
// Optional feature macro: RS_PERF_COUNTER_EN (issue / full-stall counters).
package reservation_station_pkg;

  localparam int WORD_W         = 32;
  localparam int ROB_TAG_W      = 4;
  localparam int OP_W           = 6;
  localparam int RS_SIZE_DEF    = 16;
  localparam int RS_IDX_W_DEF   = 4;

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  localparam word_t ZERO_WORD = '0;

  // Inner opcodes for integer, branch and jump instructions; NOP is zero so a
  // reset issue register reads as a harmless bubble.
  typedef enum logic [OP_W-1:0] {
    OP_NOP = 6'd0, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND
  } inner_op_e;

  // One source operand: rdy=1 means val is valid, otherwise wait on tag.
  typedef struct packed {
    logic     rdy;
    rob_tag_t tag;
    word_t    val;
  } operand_t;

  // Payload of one station entry (busy bit is kept separately).
  typedef struct packed {
    inner_op_e op;
    word_t     imm;
    word_t     pc;
    rob_tag_t  dest;
    operand_t  j;
    operand_t  k;
  } rs_entry_t;

  // Registered issue port towards the ALU.
  typedef struct packed {
    logic      valid;
    inner_op_e op;
    word_t     imm;
    word_t     pc;
    word_t     rs1val;
    word_t     rs2val;
    rob_tag_t  dest;
  } issue_t;

  // Capture a broadcast result into a waiting operand; the ALU bus wins when
  // both buses carry the same tag.
  function automatic operand_t snoop(input operand_t o,
                                     input logic alu_v, input rob_tag_t alu_tag,
                                     input word_t alu_val,
                                     input logic lsb_v, input rob_tag_t lsb_tag,
                                     input word_t lsb_val);
    operand_t r;
    r = o;
    if (!o.rdy) begin
      if (alu_v && alu_tag == o.tag) begin
        r.rdy = 1'b1;
        r.val = alu_val;
      end else if (lsb_v && lsb_tag == o.tag) begin
        r.rdy = 1'b1;
        r.val = lsb_val;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Dispatch, CDB snoop, rollback and ALU issue signals of the reservation
// station. slave = the station itself, master = its environment.
interface reservation_station_if;
  import reservation_station_pkg::*;

  logic      dispatch_signal_in;
  inner_op_e dispatch_op_in;
  word_t     dispatch_imm_in;
  word_t     dispatch_pc_in;
  logic      dispatch_rs1_ready_in;
  logic      dispatch_rs2_ready_in;
  word_t     dispatch_rs1val_in;
  word_t     dispatch_rs2val_in;
  rob_tag_t  dispatch_rs1tag_in;
  rob_tag_t  dispatch_rs2tag_in;
  rob_tag_t  dispatch_dest_in;
  logic      full_out;

  logic      alu_broadcast_signal_in;
  word_t     alu_result_in;
  rob_tag_t  alu_dest_tag_in;
  logic      lsb_broadcast_signal_in;
  word_t     lsb_result_in;
  rob_tag_t  lsb_dest_tag_in;
  logic      rob_rollback_in;

  logic      alu_calculate_signal_out;
  inner_op_e alu_op_out;
  word_t     alu_imm_out;
  word_t     alu_pc_out;
  word_t     alu_rs1val_out;
  word_t     alu_rs2val_out;
  rob_tag_t  alu_dest_out;

  modport slave (
    input  dispatch_signal_in, dispatch_op_in, dispatch_imm_in, dispatch_pc_in,
           dispatch_rs1_ready_in, dispatch_rs2_ready_in,
           dispatch_rs1val_in, dispatch_rs2val_in,
           dispatch_rs1tag_in, dispatch_rs2tag_in, dispatch_dest_in,
           alu_broadcast_signal_in, alu_result_in, alu_dest_tag_in,
           lsb_broadcast_signal_in, lsb_result_in, lsb_dest_tag_in,
           rob_rollback_in,
    output full_out, alu_calculate_signal_out, alu_op_out, alu_imm_out,
           alu_pc_out, alu_rs1val_out, alu_rs2val_out, alu_dest_out
  );

  modport master (
    output dispatch_signal_in, dispatch_op_in, dispatch_imm_in, dispatch_pc_in,
           dispatch_rs1_ready_in, dispatch_rs2_ready_in,
           dispatch_rs1val_in, dispatch_rs2val_in,
           dispatch_rs1tag_in, dispatch_rs2tag_in, dispatch_dest_in,
           alu_broadcast_signal_in, alu_result_in, alu_dest_tag_in,
           lsb_broadcast_signal_in, lsb_result_in, lsb_dest_tag_in,
           rob_rollback_in,
    input  full_out, alu_calculate_signal_out, alu_op_out, alu_imm_out,
           alu_pc_out, alu_rs1val_out, alu_rs2val_out, alu_dest_out
  );

endinterface

// File: rtl/reservation_station_priority_picker.sv
// Lowest-index priority encoder: reports whether any request bit is set and
// the index of the lowest one. Used for free-slot and ready-entry search.
module rs_priority_picker #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req_in,
  output logic             found_out,
  output logic [IDX_W-1:0] idx_out
);

  // Scan from the top down so the lowest set bit is written last and wins.
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves
    // an always_comb output unassigned would infer a latch.
    found_out = 1'b0;
    idx_out   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_in[i]) begin
        found_out = 1'b1;
        idx_out   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station between dispatcher and ALU: buffers instructions until
// both operands are known, snoops the ALU and LSB result buses, and issues the
// lowest-index ready entry each cycle through registered outputs.
// Optional feature macro: RS_PERF_COUNTER_EN adds perf_issue_cnt_out and
// perf_full_cycles_out.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE  = RS_SIZE_DEF,
  parameter int RS_IDX_W = RS_IDX_W_DEF
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  reservation_station_if.slave  bus
`ifdef RS_PERF_COUNTER_EN
  ,
  output logic [31:0]           perf_issue_cnt_out,
  output logic [31:0]           perf_full_cycles_out
`endif
);

  logic [RS_SIZE-1:0] busy_q, busy_d;
  rs_entry_t          ent_q [RS_SIZE];
  rs_entry_t          ent_d [RS_SIZE];
  issue_t             issue_q, issue_d;

  logic [RS_SIZE-1:0]  ready_vec;
  logic                free_found, rdy_found;
  logic [RS_IDX_W-1:0] free_idx, rdy_idx;
  logic                full;
  logic                do_issue;

  // Ready means busy with both operands captured in registered state.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_vec[i] = busy_q[i] && ent_q[i].j.rdy && ent_q[i].k.rdy;
    end
  end

  assign full = &busy_q;

  rs_priority_picker #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_pick (
    .req_in    (~busy_q),
    .found_out (free_found),
    .idx_out   (free_idx)
  );

  rs_priority_picker #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_ready_pick (
    .req_in    (ready_vec),
    .found_out (rdy_found),
    .idx_out   (rdy_idx)
  );

  assign do_issue = rdy_in && !bus.rob_rollback_in && rdy_found;

  // Next state: rollback flush, else wakeup + issue + dispatch in parallel.
  // The free slot comes from registered busy bits, so an entry issued this
  // cycle is never reused by a same-cycle dispatch.
  always_comb begin
    busy_d        = busy_q;
    ent_d         = ent_q;
    issue_d       = issue_q;
    issue_d.valid = 1'b0;
    if (rdy_in) begin
      if (bus.rob_rollback_in) begin
        busy_d = '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          ent_d[i].j = snoop(ent_q[i].j,
                             bus.alu_broadcast_signal_in, bus.alu_dest_tag_in, bus.alu_result_in,
                             bus.lsb_broadcast_signal_in, bus.lsb_dest_tag_in, bus.lsb_result_in);
          ent_d[i].k = snoop(ent_q[i].k,
                             bus.alu_broadcast_signal_in, bus.alu_dest_tag_in, bus.alu_result_in,
                             bus.lsb_broadcast_signal_in, bus.lsb_dest_tag_in, bus.lsb_result_in);
        end
        if (do_issue) begin
          issue_d.valid   = 1'b1;
          issue_d.op      = ent_q[rdy_idx].op;
          issue_d.imm     = ent_q[rdy_idx].imm;
          issue_d.pc      = ent_q[rdy_idx].pc;
          issue_d.rs1val  = ent_q[rdy_idx].j.val;
          issue_d.rs2val  = ent_q[rdy_idx].k.val;
          issue_d.dest    = ent_q[rdy_idx].dest;
          busy_d[rdy_idx] = 1'b0;
        end
        if (bus.dispatch_signal_in && free_found) begin
          busy_d[free_idx]     = 1'b1;
          ent_d[free_idx].op   = bus.dispatch_op_in;
          ent_d[free_idx].imm  = bus.dispatch_imm_in;
          ent_d[free_idx].pc   = bus.dispatch_pc_in;
          ent_d[free_idx].dest = bus.dispatch_dest_in;
          ent_d[free_idx].j    = snoop('{rdy: bus.dispatch_rs1_ready_in,
                                         tag: bus.dispatch_rs1tag_in,
                                         val: bus.dispatch_rs1val_in},
                                       bus.alu_broadcast_signal_in, bus.alu_dest_tag_in, bus.alu_result_in,
                                       bus.lsb_broadcast_signal_in, bus.lsb_dest_tag_in, bus.lsb_result_in);
          ent_d[free_idx].k    = snoop('{rdy: bus.dispatch_rs2_ready_in,
                                         tag: bus.dispatch_rs2tag_in,
                                         val: bus.dispatch_rs2val_in},
                                       bus.alu_broadcast_signal_in, bus.alu_dest_tag_in, bus.alu_result_in,
                                       bus.lsb_broadcast_signal_in, bus.lsb_dest_tag_in, bus.lsb_result_in);
        end
      end
    end
  end

  // Control state: busy bits and the issue register, synchronously reset.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge value regardless of statement order.
    if (rst_in) begin
      busy_q  <= '0;
      issue_q <= '0;
    end else begin
      busy_q  <= busy_d;
      issue_q <= issue_d;
    end
  end

  // Entry payload storage.
  always_ff @(posedge clk_in) begin
    // NOTE: payload is deliberately not reset; a cleared busy bit already
    // makes an entry invisible, so resetting the array only costs reset fanout.
    ent_q <= ent_d;
  end

  assign bus.full_out                 = full;
  assign bus.alu_calculate_signal_out = issue_q.valid;
  assign bus.alu_op_out               = issue_q.op;
  assign bus.alu_imm_out              = issue_q.imm;
  assign bus.alu_pc_out               = issue_q.pc;
  assign bus.alu_rs1val_out           = issue_q.rs1val;
  assign bus.alu_rs2val_out           = issue_q.rs2val;
  assign bus.alu_dest_out             = issue_q.dest;

`ifdef RS_PERF_COUNTER_EN
  logic [31:0] perf_issue_q, perf_issue_d;
  logic [31:0] perf_full_q, perf_full_d;

  // Free-running wrap-around counters; rollback does not clear them.
  always_comb begin
    perf_issue_d = perf_issue_q + 32'(do_issue);
    perf_full_d  = perf_full_q + 32'(rdy_in && full && bus.dispatch_signal_in);
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      perf_issue_q <= '0;
      perf_full_q  <= '0;
    end else begin
      perf_issue_q <= perf_issue_d;
      perf_full_q  <= perf_full_d;
    end
  end

  assign perf_issue_cnt_out   = perf_issue_q;
  assign perf_full_cycles_out = perf_full_q;
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station. Expected issues are
// queued when stimulus is driven and popped when the ALU port fires.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  always #5 clk = ~clk;

  reservation_station_if bus ();

`ifdef RS_PERF_COUNTER_EN
  logic [31:0] perf_issue;
  logic [31:0] perf_full;
`endif

  reservation_station dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus)
`ifdef RS_PERF_COUNTER_EN
    ,
    .perf_issue_cnt_out   (perf_issue),
    .perf_full_cycles_out (perf_full)
`endif
  );

  typedef struct packed {
    inner_op_e op;
    word_t     imm;
    word_t     pc;
    word_t     v1;
    word_t     v2;
    rob_tag_t  dest;
  } exp_t;

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;
  int   issued = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dispatch_signal_in      = 1'b0;
    bus.dispatch_op_in          = OP_NOP;
    bus.dispatch_imm_in         = '0;
    bus.dispatch_pc_in          = '0;
    bus.dispatch_rs1_ready_in   = 1'b0;
    bus.dispatch_rs2_ready_in   = 1'b0;
    bus.dispatch_rs1val_in      = '0;
    bus.dispatch_rs2val_in      = '0;
    bus.dispatch_rs1tag_in      = '0;
    bus.dispatch_rs2tag_in      = '0;
    bus.dispatch_dest_in        = '0;
    bus.alu_broadcast_signal_in = 1'b0;
    bus.alu_result_in           = '0;
    bus.alu_dest_tag_in         = '0;
    bus.lsb_broadcast_signal_in = 1'b0;
    bus.lsb_result_in           = '0;
    bus.lsb_dest_tag_in         = '0;
    bus.rob_rollback_in         = 1'b0;
  endtask

  task automatic dispatch(input inner_op_e op, input word_t imm, input word_t pc,
                          input logic r1, input word_t v1, input rob_tag_t t1,
                          input logic r2, input word_t v2, input rob_tag_t t2,
                          input rob_tag_t dest);
    check("no_dispatch_when_full", 32'(bus.full_out), 32'd0);
    bus.dispatch_signal_in    = 1'b1;
    bus.dispatch_op_in        = op;
    bus.dispatch_imm_in       = imm;
    bus.dispatch_pc_in        = pc;
    bus.dispatch_rs1_ready_in = r1;
    bus.dispatch_rs1val_in    = v1;
    bus.dispatch_rs1tag_in    = t1;
    bus.dispatch_rs2_ready_in = r2;
    bus.dispatch_rs2val_in    = v2;
    bus.dispatch_rs2tag_in    = t2;
    bus.dispatch_dest_in      = dest;
  endtask

  task automatic expect_issue(input string tag);
    exp_t e;
    check({tag, "_valid"}, 32'(bus.alu_calculate_signal_out), 32'd1);
    check({tag, "_queued"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      issued++;
      check({tag, "_op"},   32'(bus.alu_op_out),   32'(e.op));
      check({tag, "_imm"},  bus.alu_imm_out,       e.imm);
      check({tag, "_pc"},   bus.alu_pc_out,        e.pc);
      check({tag, "_rs1"},  bus.alu_rs1val_out,    e.v1);
      check({tag, "_rs2"},  bus.alu_rs2val_out,    e.v2);
      check({tag, "_dest"}, 32'(bus.alu_dest_out), 32'(e.dest));
    end
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_no_issue"}, 32'(bus.alu_calculate_signal_out), 32'd0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    rdy = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_valid", 32'(bus.alu_calculate_signal_out), 32'd0);
    check("reset_full",  32'(bus.full_out), 32'd0);
    check("reset_op",    32'(bus.alu_op_out), 32'd0);
    check("reset_rs1",   bus.alu_rs1val_out, 32'd0);
    check("reset_rs2",   bus.alu_rs2val_out, 32'd0);
    check("reset_dest",  32'(bus.alu_dest_out), 32'd0);
    check("reset_pc",    bus.alu_pc_out, 32'd0);

    // Both operands ready at dispatch: issue two edges later.
    dispatch(OP_ADD, 32'h11, 32'h1000, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd2);
    sb.push_back('{OP_ADD, 32'h11, 32'h1000, 32'd5, 32'd7, 4'd2});
    tick();
    idle();
    expect_idle("add_t1");
    tick();
    expect_issue("add");
    tick();
    expect_idle("add_after");

    // rs1 waits on tag 3; ALU CDB delivers it two cycles later.
    dispatch(OP_SUB, 32'h0, 32'h1004, 1'b0, 32'h0, 4'd3, 1'b1, 32'd1, 4'd0, 4'd4);
    sb.push_back('{OP_SUB, 32'h0, 32'h1004, 32'h10, 32'd1, 4'd4});
    tick();
    idle();
    tick();
    expect_idle("sub_wait");
    bus.alu_broadcast_signal_in = 1'b1;
    bus.alu_dest_tag_in         = 4'd3;
    bus.alu_result_in           = 32'h10;
    tick();
    idle();
    expect_idle("sub_woken");
    tick();
    expect_issue("sub");

    // Same-cycle LSB broadcast bypasses into the dispatched rs2.
    dispatch(OP_XOR, 32'h5, 32'h1008, 1'b1, 32'd9, 4'd0, 1'b0, 32'h0, 4'd6, 4'd7);
    bus.lsb_broadcast_signal_in = 1'b1;
    bus.lsb_dest_tag_in         = 4'd6;
    bus.lsb_result_in           = 32'hABCD;
    sb.push_back('{OP_XOR, 32'h5, 32'h1008, 32'd9, 32'hABCD, 4'd7});
    tick();
    idle();
    expect_idle("bypass_t1");
    tick();
    expect_issue("bypass");

    // Both buses carry the same tag: the ALU value is captured.
    dispatch(OP_AND, 32'h0, 32'h100C, 1'b1, 32'h3, 4'd0, 1'b0, 32'h0, 4'd5, 4'd8);
    sb.push_back('{OP_AND, 32'h0, 32'h100C, 32'h3, 32'h1111, 4'd8});
    tick();
    idle();
    bus.alu_broadcast_signal_in = 1'b1;
    bus.alu_dest_tag_in         = 4'd5;
    bus.alu_result_in           = 32'h1111;
    bus.lsb_broadcast_signal_in = 1'b1;
    bus.lsb_dest_tag_in         = 4'd5;
    bus.lsb_result_in           = 32'h2222;
    expect_idle("alu_wins_wait");
    tick();
    idle();
    tick();
    expect_issue("alu_wins");

    // Fill all 16 entries waiting on tag 1, then release them together.
    for (int i = 0; i < 16; i++) begin
      dispatch(OP_ADDI, 32'(i), 32'h2000 + 32'(4 * i), 1'b0, 32'h0, 4'd1,
               1'b1, 32'(i), 4'd0, 4'(i));
      sb.push_back('{OP_ADDI, 32'(i), 32'h2000 + 32'(4 * i), 32'h77, 32'(i), 4'(i)});
      tick();
    end
    idle();
    check("fill_full", 32'(bus.full_out), 32'd1);
    expect_idle("fill_idle");
    bus.alu_broadcast_signal_in = 1'b1;
    bus.alu_dest_tag_in         = 4'd1;
    bus.alu_result_in           = 32'h77;
    tick();
    idle();
    check("fill_full_after_wake", 32'(bus.full_out), 32'd1);
    expect_idle("fill_wake");
    for (int i = 0; i < 16; i++) begin
      tick();
      expect_issue($sformatf("drain%0d", i));
      if (i == 0) check("full_drops", 32'(bus.full_out), 32'd0);
    end
    tick();
    expect_idle("drain_done");

    // Rollback with simultaneous dispatch and wakeup flushes everything.
    for (int i = 0; i < 4; i++) begin
      dispatch(OP_OR, 32'(i), 32'h3000, 1'b0, 32'h0, 4'd2, 1'b1, 32'h1, 4'd0, 4'(i));
      tick();
    end
    idle();
    bus.rob_rollback_in = 1'b1;
    dispatch(OP_ADD, 32'h0, 32'h3100, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0, 4'd9);
    bus.alu_broadcast_signal_in = 1'b1;
    bus.alu_dest_tag_in         = 4'd2;
    bus.alu_result_in           = 32'h55;
    tick();
    idle();
    expect_idle("rollback_edge");
    check("rollback_full", 32'(bus.full_out), 32'd0);
    tick();
    expect_idle("rollback_next");
    bus.alu_broadcast_signal_in = 1'b1;
    bus.alu_dest_tag_in         = 4'd2;
    bus.alu_result_in           = 32'h55;
    tick();
    idle();
    expect_idle("rollback_late_wake");
    tick();
    expect_idle("rollback_late_wake2");

    // rdy_in low: issue suppressed, dispatch ignored, state held.
    dispatch(OP_SLT, 32'h1, 32'h4000, 1'b1, 32'hA, 4'd0, 1'b1, 32'hB, 4'd0, 4'd3);
    sb.push_back('{OP_SLT, 32'h1, 32'h4000, 32'hA, 32'hB, 4'd3});
    tick();
    rdy = 1'b0;
    dispatch(OP_SLL, 32'h2, 32'h4004, 1'b1, 32'hC, 4'd0, 1'b1, 32'hD, 4'd0, 4'd4);
    tick();
    expect_idle("stall");
    rdy = 1'b1;
    idle();
    tick();
    expect_issue("after_stall");
    tick();
    expect_idle("stall_dispatch_dropped");

    check("scoreboard_empty", 32'(sb.size()), 32'd0);

`ifdef RS_PERF_COUNTER_EN
    check("perf_issue_cnt", perf_issue, 32'(issued));
    check("perf_full_cycles", perf_full, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
